// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver
// Oversampling SPI mode-0 (CPOL=0, CPHA=0, MSB-first) slave receiver.
// All three SPI pins are resynchronised into clk; bytes are delivered as a
// one-cycle valid pulse with sot/eot framing, and each completed byte is
// echoed back on miso during the following byte slot.
module spi_byte_receiver #(
    parameter int sync_stages = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] data,
    output logic       valid,
    output logic       sot,
    output logic       eot
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    // Synchroniser chains. They are deliberately left without reset so they
    // keep tracking the pins while rst is high; that way an ss already low at
    // reset release is not mistaken for a falling edge.
    logic [sync_stages-1:0] sclk_sync_reg;
    logic [sync_stages-1:0] ss_sync_reg;
    logic [sync_stages-1:0] mosi_sync_reg;
    logic                   sclk_hist_reg;
    logic                   ss_hist_reg;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    logic [0:0] state_reg;
    logic [2:0] bitcnt_reg;
    logic [7:0] rx_reg;
    logic [7:0] tx_reg;
    logic       first_reg;
    logic [7:0] data_reg;
    logic       valid_reg;
    logic       sot_reg;
    logic       eot_reg;
    logic       eot_pend_reg;
    logic       miso_reg;

    logic [7:0] rx_next;
    logic       byte_done;

    // Shift each pin through its synchroniser chain, plus one history flop
    // on sclk and ss for edge detection.
    always_ff @(posedge clk) begin
        sclk_sync_reg <= {sclk_sync_reg[sync_stages-2:0], sclk};
        ss_sync_reg   <= {ss_sync_reg[sync_stages-2:0], ss};
        mosi_sync_reg <= {mosi_sync_reg[sync_stages-2:0], mosi};
        sclk_hist_reg <= sclk_sync_reg[sync_stages-1];
        ss_hist_reg   <= ss_sync_reg[sync_stages-1];
    end

    assign sclk_s    = sclk_sync_reg[sync_stages-1];
    assign ss_s      = ss_sync_reg[sync_stages-1];
    assign mosi_s    = mosi_sync_reg[sync_stages-1];
    assign sclk_rise = sclk_s & ~sclk_hist_reg;
    assign sclk_fall = ~sclk_s & sclk_hist_reg;
    assign ss_rise   = ss_s & ~ss_hist_reg;
    assign ss_fall   = ~ss_s & ss_hist_reg;

    assign rx_next   = {rx_reg[6:0], mosi_s};
    assign byte_done = (state_reg == ACTIVE) && sclk_rise && (bitcnt_reg == 3'd7);

    // Transaction FSM, byte assembly, echo shift register and framing pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bitcnt_reg   <= 3'd0;
            rx_reg       <= 8'h00;
            tx_reg       <= 8'h00;
            first_reg    <= 1'b0;
            data_reg     <= 8'h00;
            valid_reg    <= 1'b0;
            sot_reg      <= 1'b0;
            eot_reg      <= 1'b0;
            eot_pend_reg <= 1'b0;
            miso_reg     <= 1'b0;
        end else begin
            valid_reg    <= 1'b0;
            sot_reg      <= 1'b0;
            // A deferred eot (ss released on the byte-completing edge) fires
            // one cycle after valid so the two never overlap.
            eot_reg      <= eot_pend_reg;
            eot_pend_reg <= 1'b0;
            miso_reg     <= (state_reg == ACTIVE) ? tx_reg[7] : 1'b0;

            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        state_reg  <= ACTIVE;
                        bitcnt_reg <= 3'd0;
                        first_reg  <= 1'b1;
                        tx_reg     <= 8'h00;
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_reg     <= rx_next;
                        bitcnt_reg <= bitcnt_reg + 3'd1;
                        if (bitcnt_reg == 3'd7) begin
                            data_reg  <= rx_next;
                            valid_reg <= 1'b1;
                            sot_reg   <= first_reg;
                            first_reg <= 1'b0;
                            tx_reg    <= rx_next;
                        end
                    end else if (sclk_fall && (bitcnt_reg != 3'd0)) begin
                        // The fall right after a byte boundary is skipped:
                        // tx already presents the new MSB.
                        tx_reg <= {tx_reg[6:0], 1'b0};
                    end
                    if (ss_rise) begin
                        state_reg <= IDLE;
                        if (byte_done) begin
                            eot_pend_reg <= 1'b1;
                        end else begin
                            eot_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign miso  = miso_reg;
    assign data  = data_reg;
    assign valid = valid_reg;
    assign sot   = sot_reg;
    assign eot   = eot_reg;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver: drives the SPI pins as a mode-0 host
// with sclk = clk/8, logs valid/eot pulses and checks them against
// hand-computed expectations.
module tb_spi_byte_receiver;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic [7:0] data;
    logic       valid;
    logic       sot;
    logic       eot;

    int n_vec;
    int n_err;
    int cyc;
    int overlap_cnt;
    int orphan_sot_cnt;

    // Event log entry: {is_eot, sot, data}
    logic [9:0] ev_q[$];
    int         ev_cyc_q[$];

    spi_byte_receiver #(.sync_stages(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .sclk  (sclk),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso),
        .data  (data),
        .valid (valid),
        .sot   (sot),
        .eot   (eot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                ev_q.push_back({1'b0, sot, data});
                ev_cyc_q.push_back(cyc);
            end
            if (eot) begin
                ev_q.push_back({1'b1, 1'b0, 8'h00});
                ev_cyc_q.push_back(cyc);
            end
            if (valid && eot) overlap_cnt <= overlap_cnt + 1;
            if (sot && !valid) orphan_sot_cnt <= orphan_sot_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next logged pulse and compare it with the expected one.
    task automatic expect_ev(input string tag, input bit is_eot, input logic [7:0] d,
                             input bit s, output int ev_cyc);
        logic [9:0] obs;
        obs    = 10'h3FF;
        ev_cyc = -1;
        if (ev_q.size() > 0) begin
            obs    = ev_q.pop_front();
            ev_cyc = ev_cyc_q.pop_front();
        end
        check(tag, {22'd0, obs}, {22'd0, is_eot, s, d});
    endtask

    task automatic expect_none(input string tag);
        check(tag, ev_q.size(), 0);
        ev_q.delete();
        ev_cyc_q.delete();
    endtask

    // Send the top n bits of b MSB-first; m collects miso as the host sees it
    // just before each rising edge. rel releases ss together with the last rise.
    task automatic spi_bits(input logic [7:0] b, input int n, input bit rel,
                            output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            tick(4);
            m = {m[6:0], miso};
            if (rel && (i == n - 1)) ss = 1'b1;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_start();
        ss = 1'b0;
        tick(5);
    endtask

    task automatic spi_stop();
        tick(4);
        ss = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int         c_v;
        int         c_e;

        n_vec          = 0;
        n_err          = 0;
        cyc            = 0;
        overlap_cnt    = 0;
        orphan_sot_cnt = 0;
        rst  = 1'b1;
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(2);

        check("reset_data",  data,  8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_sot",   sot,   1'b0);
        check("reset_eot",   eot,   1'b0);
        check("reset_miso",  miso,  1'b0);

        // Single transaction of three bytes
        spi_start();
        spi_bits(8'hF0, 8, 1'b0, m1);
        spi_bits(8'hA5, 8, 1'b0, m1);
        spi_bits(8'h3C, 8, 1'b0, m1);
        spi_stop();
        expect_ev("t1_byte0", 1'b0, 8'hF0, 1'b1, c_v);
        expect_ev("t1_byte1", 1'b0, 8'hA5, 1'b0, c_v);
        expect_ev("t1_byte2", 1'b0, 8'h3C, 1'b0, c_v);
        expect_ev("t1_eot",   1'b1, 8'h00, 1'b0, c_e);
        expect_none("t1_extra");
        check("t1_data_held", data, 8'h3C);

        // Echo on miso
        spi_start();
        spi_bits(8'h81, 8, 1'b0, m1);
        spi_bits(8'h7E, 8, 1'b0, m2);
        spi_stop();
        check("echo_byte1", m1, 8'h00);
        check("echo_byte2", m2, 8'h81);
        check("echo_idle_miso", miso, 1'b0);
        expect_ev("echo_v0", 1'b0, 8'h81, 1'b1, c_v);
        expect_ev("echo_v1", 1'b0, 8'h7E, 1'b0, c_v);
        expect_ev("echo_eot", 1'b1, 8'h00, 1'b0, c_e);
        expect_none("echo_extra");

        // Partial byte is dropped
        spi_start();
        spi_bits(8'h55, 8, 1'b0, m1);
        spi_bits(8'b1101_0000, 5, 1'b0, m1);
        spi_stop();
        expect_ev("part_v", 1'b0, 8'h55, 1'b1, c_v);
        expect_ev("part_eot", 1'b1, 8'h00, 1'b0, c_e);
        expect_none("part_extra");
        spi_start();
        spi_bits(8'h12, 8, 1'b0, m1);
        spi_stop();
        expect_ev("part_next_v", 1'b0, 8'h12, 1'b1, c_v);
        expect_ev("part_next_eot", 1'b1, 8'h00, 1'b0, c_e);
        expect_none("part_next_extra");

        // ss released on the 8th rising edge
        spi_start();
        spi_bits(8'hC3, 8, 1'b1, m1);
        tick(8);
        expect_ev("coin_v", 1'b0, 8'hC3, 1'b1, c_v);
        expect_ev("coin_eot", 1'b1, 8'h00, 1'b0, c_e);
        check("coin_eot_delay", c_e - c_v, 1);
        expect_none("coin_extra");
        check("coin_overlap", overlap_cnt, 0);

        // sclk noise with ss high
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            mosi = ~mosi;
            tick(4);
        end
        tick(4);
        expect_none("noise_events");
        check("noise_miso", miso, 1'b0);
        check("noise_data_held", data, 8'hC3);

        // Reset in the middle of a byte
        spi_start();
        spi_bits(8'hFF, 4, 1'b0, m1);
        rst = 1'b1;
        tick(2);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_eot", eot, 1'b0);
        check("rst_miso", miso, 1'b0);
        rst = 1'b0;
        tick(5);
        ss = 1'b1;
        tick(8);
        expect_none("rst_no_events");
        check("rst_data_after", data, 8'h00);
        spi_start();
        spi_bits(8'h01, 8, 1'b0, m1);
        spi_stop();
        expect_ev("rst_next_v", 1'b0, 8'h01, 1'b1, c_v);
        expect_ev("rst_next_eot", 1'b1, 8'h00, 1'b0, c_e);
        expect_none("rst_next_extra");

        // Back-to-back transactions with minimum ss high time
        spi_start();
        spi_bits(8'h10, 8, 1'b0, m1);
        tick(4);
        ss = 1'b1;
        tick(3);
        ss = 1'b0;
        tick(5);
        spi_bits(8'h20, 8, 1'b0, m1);
        spi_stop();
        expect_ev("b2b_v0", 1'b0, 8'h10, 1'b1, c_v);
        expect_ev("b2b_eot0", 1'b1, 8'h00, 1'b0, c_e);
        expect_ev("b2b_v1", 1'b0, 8'h20, 1'b1, c_v);
        expect_ev("b2b_eot1", 1'b1, 8'h00, 1'b0, c_e);
        expect_none("b2b_extra");

        check("overlap_total", overlap_cnt, 0);
        check("orphan_sot", orphan_sot_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_byte_receiver.md
# spi_byte_receiver

Clock-domain front end for the display-controller load path. Oversamples an SPI mode-0 (CPOL=0, CPHA=0, MSB-first) bus with the system clock and assembles bytes. It presents each byte to the frame loader as a one-cycle `valid` pulse, with `sot` marking the first byte of a transaction and `eot` marking slave-select release. Each received byte is echoed back on `miso` during the following byte slot, so the host can verify the link.

## Interface
Parameters:
- `sync_stages`, default 2: flip-flops in each input synchroniser chain (sclk, ss, mosi); legal range 2-4.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`, idles low.
- `ss` in 1: slave select, active low, asynchronous.
- `mosi` in 1: serial data in, asynchronous.
- `miso` out 1: serial data out (echo); driven 0 while `ss` is high.
- `data` out 8: last completed byte; held until the next byte completes.
- `valid` out 1: one-cycle pulse, `data` is new.
- `sot` out 1: asserted only together with `valid`, on the first byte after `ss` falls.
- `eot` out 1: one-cycle pulse after `ss` rises, following an active transaction.

## Operation
- Synchronisers: `sclk`, `ss` and `mosi` each pass through `sync_stages` flops. One extra history flop on `sclk` and on `ss` gives the edge detectors: `sclk_rise`, `sclk_fall`, `ss_fall`, `ss_rise`. All logic downstream uses only the synchronised values.
- States:
  - IDLE: reached on reset and on `ss_rise`.
  - ACTIVE: entered on `ss_fall`. Entry clears the bit counter, sets `first` to 1 and loads the transmit shift register `tx` with 0x00.
- In IDLE, `sclk` edges are ignored and the bit counter and shift register do not change.
- ACTIVE, on `sclk_rise`:
  - `rx <= {rx[6:0], mosi_sync}` and `bitcnt <= bitcnt + 1` (3-bit counter, wraps 7 to 0).
  - When `bitcnt` was 7: `data <= {rx[6:0], mosi_sync}`, pulse `valid`, set `sot = first`, clear `first`, and load `tx` with the completed byte.
- ACTIVE, on `sclk_fall` with `bitcnt != 0`: `tx <= {tx[6:0], 1'b0}`. The falling edge right after a byte boundary does not shift, because `tx` already holds the new MSB.
- `miso = tx[7]` in ACTIVE, 0 in IDLE. This output is registered, not combinational from the pins.
- `ss_rise` in ACTIVE:
  - Go to IDLE and discard any partial byte (`bitcnt` non-zero) silently.
  - Pulse `eot`, even if zero bytes were received.
- `ss_rise` in IDLE has no effect: no `eot`.
- `ss_fall` while in ACTIVE cannot happen, since it requires a prior rise.

## Timing
- Reset values: `data`=0x00, `valid`=0, `sot`=0, `eot`=0, `miso`=0; state IDLE, `bitcnt`=0, `tx`=0, `first`=0.
- Pin to detected edge: `sync_stages`+1 clk cycles (3 at default).
- `valid`/`sot`/`data` update on the clk edge after the 8th `sclk_rise` detection. `valid` is high for exactly 1 cycle.
- `eot` normally rises on the clk edge after `ss_rise` detection.
- `eot` is never high in the same cycle as `valid`. If `ss_rise` and the 8th `sclk_rise` are detected in the same cycle:
  - The byte is completed and delivered: `valid` at cycle N+1.
  - `eot` is deferred to cycle N+2.
  - Downstream gives `valid` priority over `eot`, so this ordering is mandatory.
- Input constraints:
  - `sclk` high and low times are each at least `sync_stages`+1 clk periods.
  - `ss` setup to the first rising `sclk` is at least `sync_stages`+2 clk periods.
  - Violating these is undefined; no error detection is required.
- `miso` changes at most 1 clk after `sclk_fall` detection. Its total delay from the `sclk` pin falling edge is `sync_stages`+2 clk periods, which must be below half the `sclk` period.
- `rst` asserted mid-byte: takes effect on the next clk edge; the partial byte is discarded and no `valid` or `eot` is emitted.
- Inputs are ignored while `rst` is high.
- The first transaction after reset requires an observed `ss_fall`. If `ss` is already low at reset release, the block stays in IDLE until `ss` rises and falls again.

## Test plan
- Single transaction, bytes 0xF0, 0xA5, 0x3C, sclk = clk/8: `valid` pulses 3 times with `data` 0xF0, 0xA5, 0x3C. `sot` is set only with 0xF0. `eot` pulses once, after the last `valid`.
- Echo check, bytes 0x81 then 0x7E: host samples `miso` as 0x00 during byte 1 and 0x81 during byte 2. `miso` is 0 after `ss` rises.
- Partial byte: 0x55, then 5 clocks of 0b11010, then `ss` rises: one `valid` (0x55, `sot`=1), then `eot`, with no second `valid`. A new transaction sending 0x12 gives `data`=0x12 with `sot`=1.
- Coincident end: `ss` deasserted at the same synchronised cycle as the 8th rising edge of 0xC3: `valid` (0xC3) at cycle N+1, `eot` at cycle N+2, never overlapping.
- Noise and reset:
  - `sclk` toggling 16 times with `ss` high gives no outputs.
  - `rst` pulsed after 4 bits of 0xFF gives outputs at their reset values and no `valid`/`eot`.
  - The next full transaction of 0x01 works, with `sot`=1.
- Back-to-back transactions: `ss` high for the minimum 3 clk between two transactions of 0x10 and 0x20 gives two `sot`-tagged `valid` pulses and two `eot` pulses, in order.
